// File: rtl/rf_wb_pkg.sv
// Shared FSM state type and default widths for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Two-requester write-back request bundle: requesters drive valid/addr/data and hold them
// until the arbiter returns ready in the same cycle.
interface rf_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant; ready is combinational from valid, zero while disabled or in reset.
// On a tie the requester not granted last wins; last_grant only moves on an accepted transfer.
module rr_arb2 (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    rf_wb_arbiter_if.slave req,
    output logic           gnt0,
    output logic           gnt1
);

    // 1 means requester 1 holds the most recent grant, so requester 0 wins the first tie.
    logic last_grant;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req.req0_valid && req.req1_valid) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = req.req0_valid;
                gnt1 = req.req1_valid;
            end
        end
    end

    assign req.req0_ready = gnt0 && rst_n;
    assign req.req1_ready = gnt1 && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt0) begin
            last_grant <= 1'b0;
        end else if (gnt1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two write-back requesters onto one register-file write port; accepted writes appear
// one cycle after the handshake. RF_WB_CLEAR_EN adds a post-reset sweep zeroing registers 1..max.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              busy_o
);

    rf_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_bus ();

    assign req_bus.req0_valid = req0_valid_i;
    assign req_bus.req0_addr  = req0_addr_i;
    assign req_bus.req0_data  = req0_data_i;
    assign req_bus.req1_valid = req1_valid_i;
    assign req_bus.req1_addr  = req1_addr_i;
    assign req_bus.req1_data  = req1_data_i;
    assign req0_ready_o       = req_bus.req0_ready;
    assign req1_ready_o       = req_bus.req1_ready;

    logic              clr_state;
    logic              run_state;
    logic [ADDR_W-1:0] clr_addr;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

`ifdef RF_WB_CLEAR_EN
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Address 0 is hard-wired, so the sweep covers 1..max and leaves RUN only via reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign clr_state = (state_q == ST_CLEAR);
    assign run_state = (state_q == ST_RUN);
    assign clr_addr  = clr_cnt_q;
`else
    assign clr_state = 1'b0;
    assign run_state = 1'b1;
    assign clr_addr  = '0;
`endif

    rr_arb2 u_arb (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (run_state),
        .req   (req_bus),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign acc_addr = gnt1 ? req_bus.req1_addr : req_bus.req0_addr;
    assign acc_data = gnt1 ? req_bus.req1_data : req_bus.req0_data;

    // During the sweep the registers track the clear write so the last swept address is held in RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (clr_state) begin
            we_q    <= 1'b0;
            waddr_q <= clr_addr;
            wdata_q <= '0;
        end else if (gnt0 || gnt1) begin
            we_q    <= (acc_addr != '0);
            waddr_q <= acc_addr;
            wdata_q <= acc_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    // Clear writes bypass the registers so they start in the first cycle after reset release.
    assign busy_o     = clr_state && rst_ni;
    assign rf_we_o    = busy_o ? 1'b1 : we_q;
    assign rf_waddr_o = busy_o ? clr_addr : waddr_q;
    assign rf_wdata_o = busy_o ? '0 : wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a grant-rule model.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int NCLR = (1 << AW) - 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;

    rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (bus.req0_valid),
        .req0_ready_o (bus.req0_ready),
        .req0_addr_i  (bus.req0_addr),
        .req0_data_i  (bus.req0_data),
        .req1_valid_i (bus.req1_valid),
        .req1_ready_o (bus.req1_ready),
        .req1_addr_i  (bus.req1_addr),
        .req1_data_i  (bus.req1_data),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .busy_o       (busy)
    );

    int tests = 0;
    int fails = 0;

    // Model state: last granted requester and the held write-port address/data.
    int            m_last;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    // Requesters must hold valid/addr/data until accepted.
    bit            p0 = 1'b0, p1 = 1'b0;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0) assert (bus.req0_valid && bus.req0_addr == pa0 && bus.req0_data == pd0)
                else $error("requester 0 changed before acceptance");
            if (p1) assert (bus.req1_valid && bus.req1_addr == pa1 && bus.req1_data == pd1)
                else $error("requester 1 changed before acceptance");
            p0 = bus.req0_valid && !bus.req0_ready; pa0 = bus.req0_addr; pd0 = bus.req0_data;
            p1 = bus.req1_valid && !bus.req1_ready; pa1 = bus.req1_addr; pd1 = bus.req1_data;
        end else begin
            p0 = 1'b0;
            p1 = 1'b0;
        end
    end

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1;
        m_wdata = '0;
`ifdef RF_WB_CLEAR_EN
        m_waddr = AW'(NCLR);
`else
        m_waddr = '0;
`endif
    endtask

    task automatic wait_clear();
`ifdef RF_WB_CLEAR_EN
        repeat (NCLR) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        bus.req0_valid = 1'b1; bus.req0_addr = AW'(4);
        bus.req1_valid = 1'b1; bus.req1_addr = AW'(6);
        rst_n = 1'b0;
        #3;
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h, want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        tests++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: ready0=%b ready1=%b, want 0/0", bus.req0_ready, bus.req1_ready);
        end
        drive_idle();
    endtask

`ifdef RF_WB_CLEAR_EN
    task automatic test_clear();
        do_reset();
        for (int k = 1; k <= NCLR; k++) begin
            #2;
            tests++;
            if (rf_we !== 1'b1 || rf_waddr !== AW'(k) || rf_wdata !== '0 || busy !== 1'b1 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL clear_step k=%0d: we=%b addr=%0d data=%h busy=%b, want 1/%0d/0/1",
                         k, rf_we, rf_waddr, rf_wdata, busy, k);
            end
            @(posedge clk);
            #1;
        end
        #2;
        tests++;
        if (busy !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== AW'(NCLR)) begin
            fails++;
            $display("FAIL clear_done: busy=%b we=%b addr=%0d, want 0/0/%0d", busy, rf_we, rf_waddr, NCLR);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        repeat (9) @(posedge clk);
        #2;
        tests++;
        if (rf_waddr !== AW'(10) || busy !== 1'b1) begin
            fails++;
            $display("FAIL midclr_count: addr=%0d busy=%b, want 10/1", rf_waddr, busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midclr_zero: we=%b addr=%0d data=%h busy=%b, want 0/0/0/0",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== AW'(1) || busy !== 1'b1) begin
            fails++;
            $display("FAIL midclr_restart: we=%b addr=%0d busy=%b, want 1/1/1", rf_we, rf_waddr, busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rf_waddr !== AW'(2)) begin
            fails++;
            $display("FAIL midclr_next: addr=%0d, want 2", rf_waddr);
        end
    endtask
`endif

    task automatic test_single();
        do_reset();
        wait_clear();
        bus.req0_valid = 1'b1; bus.req0_addr = AW'(5); bus.req0_data = 32'hDEADBEEF;
        #2;
        tests++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_ready: ready0=%b ready1=%b, want 1/0", bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        #1;
        drive_idle();
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== AW'(5) || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_write: we=%b addr=%0d data=%h, want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== AW'(5) || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_hold: we=%b addr=%0d data=%h, want 0/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_tie();
        int exp_g;
        do_reset();
        wait_clear();
        bus.req0_valid = 1'b1; bus.req0_addr = AW'(3); bus.req0_data = 32'h0000_0003;
        bus.req1_valid = 1'b1; bus.req1_addr = AW'(7); bus.req1_data = 32'h0000_0007;
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            #2;
            tests++;
            if (bus.req0_ready !== (exp_g == 0) || bus.req1_ready !== (exp_g == 1) || busy !== 1'b0) begin
                fails++;
                $display("FAIL tie_grant i=%0d: ready0=%b ready1=%b busy=%b, want grant %0d busy 0",
                         i, bus.req0_ready, bus.req1_ready, busy, exp_g);
            end
            @(posedge clk);
            #1;
            tests++;
            if (rf_we !== 1'b1 || rf_waddr !== ((exp_g == 0) ? AW'(3) : AW'(7))) begin
                fails++;
                $display("FAIL tie_write i=%0d: we=%b addr=%0d, want 1/%0d", i, rf_we, rf_waddr,
                         (exp_g == 0) ? 3 : 7);
            end
        end
        drive_idle();
    endtask

    task automatic test_addr0();
        do_reset();
        wait_clear();
        bus.req1_valid = 1'b1; bus.req1_addr = '0; bus.req1_data = 32'h0000_1234;
        #2;
        tests++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL addr0_ready: ready0=%b ready1=%b, want 0/1", bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        #1;
        drive_idle();
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL addr0_we: we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wait_clear();
        bus.req0_valid = 1'b1; bus.req0_addr = AW'(9); bus.req0_data = 32'hA5A5_0009;
        @(posedge clk);
        #1;
        drive_idle();
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== AW'(9)) begin
            fails++;
            $display("FAIL areset_pre: we=%b addr=%0d, want 1/9", rf_we, rf_waddr);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            fails++;
            $display("FAIL areset_zero: we=%b addr=%0d data=%h, want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_random();
        wr_t  pend [2];
        bit   act  [2];
        int   waits[2];
        int   g;
        logic m_we;
        do_reset();
        wait_clear();
        act = '{1'b0, 1'b0};
        waits = '{0, 0};
        pend = '{'0, '0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!act[r] && $urandom_range(0, 2) != 0) begin
                    act[r] = 1'b1;
                    pend[r].addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    pend[r].data = $urandom;
                end
            end
            bus.req0_valid = act[0]; bus.req0_addr = pend[0].addr; bus.req0_data = pend[0].data;
            bus.req1_valid = act[1]; bus.req1_addr = pend[1].addr; bus.req1_data = pend[1].data;
            #2;
            // A lone requester wins; on a tie the one not granted last wins.
            if (act[0] && act[1]) g = 1 - m_last;
            else if (act[0])      g = 0;
            else if (act[1])      g = 1;
            else                  g = -1;
            tests++;
            if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
                fails++;
                $display("FAIL rand_ready cyc=%0d: ready0=%b ready1=%b, want grant %0d",
                         cyc, bus.req0_ready, bus.req1_ready, g);
            end
            for (int r = 0; r < 2; r++) waits[r] = (act[r] && g != r) ? waits[r] + 1 : 0;
            tests++;
            if (waits[0] > 1 || waits[1] > 1) begin
                fails++;
                $display("FAIL rand_fair cyc=%0d: waits %0d/%0d, want <=1", cyc, waits[0], waits[1]);
            end
            @(posedge clk);
            #1;
            m_we = 1'b0;
            if (g >= 0) begin
                m_last  = g;
                act[g]  = 1'b0;
                m_we    = (pend[g].addr != '0);
                m_waddr = pend[g].addr;
                m_wdata = pend[g].data;
            end
            tests++;
            if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
                fails++;
                $display("FAIL rand_write cyc=%0d: we=%b addr=%0d data=%h, want %b/%0d/%h",
                         cyc, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef RF_WB_CLEAR_EN
        test_clear();
        test_reset_mid_clear();
`endif
        test_single();
        test_tie();
        test_addr0();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid_i / req1_valid_i  input  1  write request pending.
REQ-006 SHALL have ports req0_ready_o / req1_ready_o  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_addr_i / req1_addr_i  input  ADDR_W  destination register.
REQ-008 SHALL have ports req0_data_i / req1_data_i  input  DATA_W  write data.
REQ-009 SHALL have port rf_we_o  output  1  register file write enable.
REQ-010 SHALL have port rf_waddr_o  output  ADDR_W  register file write address.
REQ-011 SHALL have port rf_wdata_o  output  DATA_W  register file write data.
REQ-012 SHALL have port busy_o  output  1  clear sequence in progress.

Function
REQ-013 SHALL complete a transfer on reqN when reqN_valid_i and reqN_ready_o are both 1 at a rising edge.
REQ-014 SHALL drive reqN_ready_o combinationally, only in state RUN, to at most one requester per cycle.
REQ-015 SHALL grant the only valid requester when exactly one reqN_valid_i is 1.
REQ-016 SHALL, when both are valid, grant the requester not granted last; last_grant resets to 1, so req0 wins the first tie.
REQ-017 SHALL update last_grant only on a completed transfer.
REQ-018 SHALL register accepted requests: rf_we_o/rf_waddr_o/rf_wdata_o present the accepted write exactly one cycle after the handshake, rf_we_o high for exactly one cycle.
REQ-019 SHALL accept writes with address 0 (ready asserted) but keep rf_we_o at 0 for them.
REQ-020 SHALL, without an accepted request in RUN, drive rf_we_o 0; rf_waddr_o/rf_wdata_o hold last value.
REQ-021 SHALL guarantee a continuously valid requester is accepted within 2 cycles in RUN.
REQ-022 SHALL require requesters to hold valid/addr/data stable until accepted (bench asserts this).
REQ-023 SHALL implement FSM states CLEAR and RUN; CLEAR->RUN after the write to address 2^ADDR_W-1; RUN is terminal until reset.
REQ-024 SHALL in CLEAR, each cycle, drive rf_we_o=1, rf_waddr_o=clear counter, rf_wdata_o=0, counter increments 1..2^ADDR_W-1, both ready_o 0, busy_o 1.
REQ-025 SHALL drive busy_o 0 in RUN.

Reset
REQ-026 SHALL on rst_ni low asynchronously force rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, last_grant=1, clear counter=1, both ready_o 0.
REQ-027 SHALL enter CLEAR (macro defined) or RUN (macro undefined) after reset release.
REQ-028 SHALL restart the clear sequence from address 1 on reset asserted mid-CLEAR; in-flight accepted writes are dropped.

Configuration
REQ-029 SHALL compile the CLEAR state and counter only when RF_WB_CLEAR_EN is defined; otherwise the FSM is RUN-only, busy_o tied 0, requests accepted first cycle after reset release.

Structure
REQ-030 SHALL place the FSM state enum (CLEAR, RUN) and ADDR_W/DATA_W default constants in shared package rf_wb_pkg.
REQ-031 SHALL contain a sub-module rr_arb2 (2-way round-robin grant with last_grant register); no other sub-modules.

Verification
REQ-032 Macro on, reset release, no requests -> 31 cycles rf_we_o=1, addresses 1..31, data 0, busy_o 1; then busy_o 0, rf_we_o 0.
REQ-033 RUN, req0 only, addr 5, data 0xDEADBEEF -> req0_ready_o 1 same cycle; next cycle rf_we_o 1, rf_waddr_o 5, rf_wdata_o 0xDEADBEEF.
REQ-034 RUN, both valid continuously (req0 addr 3, req1 addr 7) after reset -> grants alternate 0,1,0,1; rf_waddr_o sequence 3,7,3,7.
REQ-035 RUN, req1 addr 0 data 0x1234 -> req1_ready_o 1, rf_we_o stays 0.
REQ-036 Macro on, rst_ni pulsed low when counter = 10 -> outputs zeroed immediately; after release clear restarts at address 1.
REQ-037 Macro off, both valid first cycle after reset -> req0 granted first, busy_o 0 throughout.
